rf_mode_host_driver: RTL

Host-side mode sequencer for the RF transceiver's M0/M1/AUX interface. It drives M1/M0 into the transceiver's mode controller and uses AUX as the module-idle handshake. A mode request is accepted through a valid/ready handshake. The block waits for AUX to be stably high, drives the new M1/M0 value, waits a settle time, then waits for AUX to be stably high again before signalling completion. Failed waits end with a timeout error.

---
 rtl/rf_mode_host_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rf_mode_host_driver.sv
// Host-side M1/M0 mode sequencer for the RF transceiver, using AUX as the module-idle handshake.
// Flow: wait for AUX stable high, drive pins, settle, wait for AUX stable high again.
module rf_mode_host_driver #(
  parameter logic [1:0] DEFAULT_MODE    = 2'd3,
  parameter int         PRE_SWITCH_WAIT = 2,
  parameter int         SETTLE_CYCLES   = 2000,
  parameter int         TIMEOUT_CYCLES  = 200000
) (
  input  logic       internal_clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       AUX,
  output logic       M0,
  output logic       M1,
  output logic [1:0] cur_mode,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  localparam int HW = $clog2(PRE_SWITCH_WAIT) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(PRE_SWITCH_WAIT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_AUX   = 3'd1,
    DRIVE      = 3'd2,
    SETTLE     = 3'd3,
    WAIT_READY = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      target;
  logic [1:0]      mode_q;
  logic            aux_s1;
  logic            aux_s;
  logic [HW-1:0]   hcnt;
  logic [SW-1:0]   scnt;
  logic [TW-1:0]   tcnt;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high exactly while the sequencer sits in IDLE.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign M1        = mode_q[1];
  assign M0        = mode_q[0];
  assign cur_mode  = mode_q;
  assign state_dbg = state;

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state       <= IDLE;
      target      <= DEFAULT_MODE;
      mode_q      <= DEFAULT_MODE;
      aux_s1      <= 1'b0;
      aux_s       <= 1'b0;
      hcnt        <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      aux_s1      <= AUX;
      aux_s       <= aux_s1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target <= req_mode;
            if (req_mode == mode_q) begin
              done <= 1'b1;
            end else begin
              state <= WAIT_AUX;
              hcnt  <= '0;
              tcnt  <= '0;
            end
          end
        end
        // Both AUX-wait phases share the stable-high rule; the exit is checked before the timeout.
        WAIT_AUX, WAIT_READY: begin
          if (aux_s && (hcnt == H_LAST)) begin
            hcnt <= '0;
            tcnt <= '0;
            if (state == WAIT_AUX) begin
              state <= DRIVE;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (tcnt == T_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            hcnt        <= '0;
            tcnt        <= '0;
          end else begin
            hcnt <= aux_s ? hcnt + 1'b1 : '0;
            tcnt <= tcnt + 1'b1;
          end
        end
        DRIVE: begin
          mode_q <= target;
          scnt   <= '0;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (scnt == S_LAST) begin
            state <= WAIT_READY;
            scnt  <= '0;
            hcnt  <= '0;
            tcnt  <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
